// File: rtl/reg_file_mp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp_pkg
//  Description : Shared constants and helpers for the multi-port register
//                file: default geometry, address-width derivation and the
//                hardwired-zero register index.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_file_mp_pkg;

  localparam int c_def_xlen  = 32;
  localparam int c_def_nregs = 32;

  // Index of the register that reads as zero when ZERO_REG is enabled.
  localparam int c_reg_zero  = 0;

  // Address width for a register file of n entries (n is a power of 2, >= 2).
  function automatic int addr_width(input int n);
    return $clog2(n);
  endfunction

  function automatic logic is_zero_reg(input int addr);
    return (addr == c_reg_zero);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp_if
//  Description : Read / write / claim bus of the multi-port register file.
//                master = issue/writeback side, slave = register file.
//  Ports       : rs_addr/rs_data/rs_busy  read ports (packed, port p at p*W)
//                wr_en/wr_addr/wr_data    write ports (packed per port)
//                claim_en/claim_addr      mark a register pending
//                busy_cnt                 registered count of pending regs
//  Revision    : 1.0  initial release
// ============================================================================
interface reg_file_mp_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
);
  localparam int c_aw = $clog2(NREGS);

  logic [NREAD*c_aw-1:0]   rs_addr;
  logic [NREAD*XLEN-1:0]   rs_data;
  logic [NREAD-1:0]        rs_busy;
  logic [NWRITE-1:0]       wr_en;
  logic [NWRITE*c_aw-1:0]  wr_addr;
  logic [NWRITE*XLEN-1:0]  wr_data;
  logic                    claim_en;
  logic [c_aw-1:0]         claim_addr;
  logic [c_aw:0]           busy_cnt;

  modport master (
    output rs_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rs_data, rs_busy, busy_cnt
  );

  modport slave (
    input  rs_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rs_data, rs_busy, busy_cnt
  );

endinterface
`default_nettype wire

// File: rtl/reg_file_mp_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp_read_port
//  Description : One combinational read port: zero-register check, priority
//                select among same-cycle writes (highest port wins), optional
//                write-to-read bypass, busy output.
//  Ports       : i_rd_addr              read address
//                i_st_data / i_st_busy  stored value / busy bit at i_rd_addr
//                i_wr_en/addr/data      all write ports, packed
//                o_rd_data / o_rd_busy  read result
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file_mp_read_port
  import reg_file_mp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NWRITE   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]          i_rd_addr,
  input  logic [XLEN-1:0]        i_st_data,
  input  logic                   i_st_busy,
  input  logic [NWRITE-1:0]      i_wr_en,
  input  logic [NWRITE*AW-1:0]   i_wr_addr,
  input  logic [NWRITE*XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0]        o_rd_data,
  output logic                   o_rd_busy
);

  logic            w_hit;
  logic [XLEN-1:0] w_hit_data;
  logic            w_is_zero;

  assign w_is_zero = (ZERO_REG != 0) && is_zero_reg(int'(i_rd_addr));

  // Ascending scan: a later (higher-index) match overwrites an earlier one,
  // which gives the highest write port priority.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int w = 0; w < NWRITE; w++) begin
      if (i_wr_en[w] && (i_wr_addr[w*AW +: AW] == i_rd_addr)) begin
        w_hit      = 1'b1;
        w_hit_data = i_wr_data[w*XLEN +: XLEN];
      end
    end
  end

  // Zero register beats bypass; a bypassed write retires the pending result,
  // so the port reports not-busy even if the stored busy bit is still set.
  always_comb begin
    o_rd_data = i_st_data;
    o_rd_busy = i_st_busy;
    if (w_is_zero) begin
      o_rd_data = '0;
      o_rd_busy = 1'b0;
    end else if ((BYPASS != 0) && w_hit) begin
      o_rd_data = w_hit_data;
      o_rd_busy = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp
//  Description : Parametrised multi-port register file with write-to-read
//                bypass and a per-register pending-write scoreboard.
//  Ports       : clk    clock, rising edge
//                rst_n  asynchronous active-low reset
//                bus    reg_file_mp_if.slave (reads, writes, claims, busy_cnt)
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int XLEN     = c_def_xlen,
  parameter int NREGS    = c_def_nregs,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_mp_if.slave  bus
);

  localparam int c_aw = addr_width(NREGS);

  logic [XLEN-1:0]   r_mem [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic [c_aw:0]     r_busy_cnt;

  logic [NREGS-1:0]  w_busy_nxt;
  logic [c_aw:0]     w_busy_cnt_nxt;
  logic [NWRITE-1:0] w_wr_ok;
  logic              w_claim_ok;

  logic [XLEN-1:0]   w_st_data [NREAD];
  logic [NREAD-1:0]  w_st_busy;
  logic [XLEN-1:0]   w_rd_data [NREAD];
  logic [NREAD-1:0]  w_rd_busy;

  // Writes and claims aimed at the hardwired zero register are dropped here,
  // so register 0 never stores data and never becomes busy.
  always_comb begin
    w_wr_ok = '0;
    for (int w = 0; w < NWRITE; w++) begin
      w_wr_ok[w] = bus.wr_en[w] &&
                   !((ZERO_REG != 0) && is_zero_reg(int'(bus.wr_addr[w*c_aw +: c_aw])));
    end
  end

  assign w_claim_ok = bus.claim_en &&
                      !((ZERO_REG != 0) && is_zero_reg(int'(bus.claim_addr)));

  // Storage. Non-blocking writes issued in ascending port order: for a shared
  // address the last (highest-index) port's value is the one that lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NWRITE; w++) begin
        if (w_wr_ok[w]) begin
          r_mem[bus.wr_addr[w*c_aw +: c_aw]] <= bus.wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Busy scoreboard: writes clear first, then a claim sets, so a claim and a
  // write to the same register in one cycle leaves it pending (new producer).
  always_comb begin
    w_busy_nxt = r_busy;
    for (int w = 0; w < NWRITE; w++) begin
      if (w_wr_ok[w]) begin
        w_busy_nxt[bus.wr_addr[w*c_aw +: c_aw]] = 1'b0;
      end
    end
    if (w_claim_ok) begin
      w_busy_nxt[bus.claim_addr] = 1'b1;
    end
  end

  // Count is taken from the next-state vector so it moves on the same edge
  // as the busy bits it describes.
  always_comb begin
    w_busy_cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_busy_cnt_nxt = w_busy_cnt_nxt + {{c_aw{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  assign bus.busy_cnt = r_busy_cnt;

  for (genvar p = 0; p < NREAD; p++) begin : g_rd_port
    logic [c_aw-1:0] w_addr;

    assign w_addr       = bus.rs_addr[p*c_aw +: c_aw];
    assign w_st_data[p] = r_mem[w_addr];
    assign w_st_busy[p] = r_busy[w_addr];

    reg_file_mp_read_port #(
      .XLEN     (XLEN),
      .AW       (c_aw),
      .NWRITE   (NWRITE),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .i_rd_addr (w_addr),
      .i_st_data (w_st_data[p]),
      .i_st_busy (w_st_busy[p]),
      .i_wr_en   (bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .o_rd_data (w_rd_data[p]),
      .o_rd_busy (w_rd_busy[p])
    );

    assign bus.rs_data[p*XLEN +: XLEN] = w_rd_data[p];
  end

  assign bus.rs_busy = w_rd_busy;

endmodule
`default_nettype wire
